// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS instruction/data memory models.
package mips_mem_pkg;

  typedef logic [31:0] word_t;

  localparam word_t NOP_WORD  = '0;
  localparam word_t BOOT_ADDR = 32'hBFC00000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } rom_state_t;

  // Reverses byte order: little-endian storage to big-endian CPU port.
  function automatic word_t swap_bytes(input word_t w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mips_rom_wait_ctr.sv
// Wait-state sequencer for instruction fetches: counts latency, signals when
// to latch read data, and drives the waitrequest handshake.
module mips_rom_wait_ctr
  import mips_mem_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req,
  input  logic       i_addr_chg,
  input  logic [2:0] i_latency,
  output logic       o_waitrequest,
  output logic       o_latch_en
);

  rom_state_t r_state;
  rom_state_t w_state_nx;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    o_latch_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          w_state_nx = ST_WAIT;
          w_cnt_nx   = i_latency - 3'd1;
        end
      end
      ST_WAIT: begin
        // An address change abandons the fetch in flight and restarts the count.
        if (!i_req) begin
          w_state_nx = ST_IDLE;
        end else if (i_addr_chg) begin
          w_cnt_nx = i_latency - 3'd1;
        end else if (r_cnt == '0) begin
          o_latch_en = 1'b1;
          w_state_nx = ST_DONE;
        end else begin
          w_cnt_nx = r_cnt - 3'd1;
        end
      end
      ST_DONE: begin
        if (!i_req) begin
          w_state_nx = ST_IDLE;
        end else if (i_addr_chg) begin
          w_state_nx = ST_WAIT;
          w_cnt_nx   = i_latency - 3'd1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign o_waitrequest = i_req && ((r_state != ST_DONE) || i_addr_chg);

endmodule

// File: rtl/mips_instr_rom.sv
// Loadable instruction memory: streaming load port, boot-window fetch decode,
// optional byte swap, sticky address-fault flag and optional wait states.
module mips_instr_rom
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = BOOT_ADDR,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned BYTE_SWAP    = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [31:0]              load_data,
  output logic                     load_ready,
  output logic [$clog2(DEPTH):0]   prog_len,
  input  logic                     instr_read,
  input  logic [31:0]              instr_address,
  output logic [31:0]              instr_readdata,
  output logic                     instr_waitrequest,
  output logic                     addr_fault
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEN = DEPTH[AW:0];

  word_t         r_mem [DEPTH];
  logic [AW:0]   r_prog_len;
  logic          r_fault;

  word_t         w_offset;
  logic [AW-1:0] w_index;
  logic          w_in_window;
  logic          w_hit;
  word_t         w_stored;
  word_t         w_word;
  logic          w_wr;

  assign w_offset    = instr_address - BASE_ADDR;
  assign w_index     = w_offset[AW+1:2];
  assign w_in_window = (w_offset[31:AW+2] == '0) && (w_offset[1:0] == 2'b00);
  assign w_hit       = w_in_window && ({1'b0, w_index} < r_prog_len);
  assign w_stored    = r_mem[w_index];
  assign w_word      = !w_hit ? NOP_WORD :
                       (BYTE_SWAP != 0) ? swap_bytes(w_stored) : w_stored;

  assign load_ready = (r_prog_len != FULL_LEN);
  assign prog_len   = r_prog_len;
  assign addr_fault = r_fault;
  assign w_wr       = load_valid && load_ready && !load_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prog_len <= '0;
      r_fault    <= 1'b0;
    end else begin
      if (load_start) begin
        r_prog_len <= '0;
      end else if (w_wr) begin
        r_prog_len <= r_prog_len + 1'b1;
      end
      if (load_start) begin
        r_fault <= 1'b0;
      end else if (instr_read && !w_in_window) begin
        r_fault <= 1'b1;
      end
    end
  end

  // Array content is never reset; prog_len gates every read instead.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_prog_len[AW-1:0]] <= load_data;
    end
  end

  if (READ_LATENCY > 0) begin : g_wait
    word_t r_prev_addr;
    word_t r_rdata;
    logic  w_addr_chg;
    logic  w_latch_en;
    logic  w_wait;

    assign w_addr_chg = (instr_address != r_prev_addr);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_prev_addr <= '0;
        r_rdata     <= NOP_WORD;
      end else begin
        r_prev_addr <= instr_address;
        if (w_latch_en) begin
          r_rdata <= w_word;
        end
      end
    end

    mips_rom_wait_ctr u_wait_ctr (
      .i_clk        (clk),
      .i_rst_n      (reset_n),
      .i_req        (instr_read),
      .i_addr_chg   (w_addr_chg),
      .i_latency    (3'(READ_LATENCY)),
      .o_waitrequest(w_wait),
      .o_latch_en   (w_latch_en)
    );

    assign instr_readdata    = r_rdata;
    assign instr_waitrequest = reset_n && w_wait;
  end else begin : g_comb
    assign instr_readdata    = w_word;
    assign instr_waitrequest = 1'b0;
  end

endmodule

// File: tb/tb_mips_instr_rom.sv
// Directed bench for mips_instr_rom across three parameter sets.
module tb_mips_instr_rom;

  logic clk;
  logic rst_n;
  int unsigned total = 0;
  int unsigned bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A: DEPTH 64, L=0, swap on
  logic a_ls, a_lv, a_lr, a_rd, a_wr, a_flt;
  logic [31:0] a_ld, a_addr, a_data;
  logic [6:0]  a_pl;
  // B: DEPTH 4, L=3, swap off
  logic b_ls, b_lv, b_lr, b_rd, b_wr, b_flt;
  logic [31:0] b_ld, b_addr, b_data;
  logic [2:0]  b_pl;
  // C: DEPTH 8, L=2, swap on, private reset
  logic c_rst, c_ls, c_lv, c_lr, c_rd, c_wr, c_flt;
  logic [31:0] c_ld, c_addr, c_data;
  logic [3:0]  c_pl;

  mips_instr_rom #(.BASE_ADDR(32'hBFC00000), .DEPTH(64), .READ_LATENCY(0), .BYTE_SWAP(1)) u_a (
    .clk(clk), .reset_n(rst_n), .load_start(a_ls), .load_valid(a_lv), .load_data(a_ld),
    .load_ready(a_lr), .prog_len(a_pl), .instr_read(a_rd), .instr_address(a_addr),
    .instr_readdata(a_data), .instr_waitrequest(a_wr), .addr_fault(a_flt));

  mips_instr_rom #(.BASE_ADDR(32'hBFC00000), .DEPTH(4), .READ_LATENCY(3), .BYTE_SWAP(0)) u_b (
    .clk(clk), .reset_n(rst_n), .load_start(b_ls), .load_valid(b_lv), .load_data(b_ld),
    .load_ready(b_lr), .prog_len(b_pl), .instr_read(b_rd), .instr_address(b_addr),
    .instr_readdata(b_data), .instr_waitrequest(b_wr), .addr_fault(b_flt));

  mips_instr_rom #(.BASE_ADDR(32'hBFC00000), .DEPTH(8), .READ_LATENCY(2), .BYTE_SWAP(1)) u_c (
    .clk(clk), .reset_n(c_rst), .load_start(c_ls), .load_valid(c_lv), .load_data(c_ld),
    .load_ready(c_lr), .prog_len(c_pl), .instr_read(c_rd), .instr_address(c_addr),
    .instr_readdata(c_data), .instr_waitrequest(c_wr), .addr_fault(c_flt));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        flt;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load_a(input logic [31:0] w);
    @(negedge clk); a_lv = 1'b1; a_ld = w;
    @(negedge clk); a_lv = 1'b0;
  endtask

  task automatic load_b(input logic [31:0] w);
    @(negedge clk); b_lv = 1'b1; b_ld = w;
    @(negedge clk); b_lv = 1'b0;
  endtask

  task automatic load_c(input logic [31:0] w);
    @(negedge clk); c_lv = 1'b1; c_ld = w;
    @(negedge clk); c_lv = 1'b0;
  endtask

  task automatic pulse_start_b();
    @(negedge clk); b_ls = 1'b1; b_rd = 1'b0;
    @(negedge clk); b_ls = 1'b0;
  endtask

  // Counts post-edge samples with waitrequest high, bounded by 20 cycles.
  task automatic fetch_b(input logic [31:0] addr, input logic [31:0] exp, input string nm);
    int unsigned n = 0;
    @(negedge clk); b_rd = 1'b0;
    @(negedge clk); b_rd = 1'b1; b_addr = addr;
    #1;
    check({nm, "_wr_req"}, {31'b0, b_wr}, 32'd1);
    while (b_wr && n < 20) begin
      @(posedge clk); #1;
      if (b_wr) n++;
    end
    check({nm, "_waits"}, n, 32'd3);
    check({nm, "_data"}, b_data, exp);
  endtask

  task automatic fetch_c(input logic [31:0] addr, input logic [31:0] exp, input string nm);
    int unsigned n = 0;
    @(negedge clk); c_rd = 1'b0;
    @(negedge clk); c_rd = 1'b1; c_addr = addr;
    #1;
    while (c_wr && n < 20) begin
      @(posedge clk); #1;
      if (c_wr) n++;
    end
    check({nm, "_waits"}, n, 32'd2);
    check({nm, "_data"}, c_data, exp);
  endtask

  initial begin
    int unsigned n;
    vecs[0] = '{32'hBFC00000, 32'h00004224, 1'b0};
    vecs[1] = '{32'hBFC00004, 32'h08000000, 1'b0};
    vecs[2] = '{32'hBFC00008, 32'h78563412, 1'b0};
    vecs[3] = '{32'hBFC0000C, 32'h00000000, 1'b0};
    vecs[4] = '{32'hBFC000FC, 32'h00000000, 1'b0};
    vecs[5] = '{32'hBFC00100, 32'h00000000, 1'b1};
    vecs[6] = '{32'hBFBFFFFC, 32'h00000000, 1'b1};

    rst_n = 1'b0; c_rst = 1'b0;
    a_ls = 0; a_lv = 0; a_ld = '0; a_rd = 0; a_addr = '0;
    b_ls = 0; b_lv = 0; b_ld = '0; b_rd = 0; b_addr = '0;
    c_ls = 0; c_lv = 0; c_ld = '0; c_rd = 0; c_addr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; c_rst = 1'b1;
    #1;
    check("rst_a_ready", {31'b0, a_lr}, 32'd1);
    check("rst_a_len", a_pl, 32'd0);
    check("rst_a_wr", {31'b0, a_wr}, 32'd0);
    check("rst_a_flt", {31'b0, a_flt}, 32'd0);
    check("rst_b_ready", {31'b0, b_lr}, 32'd1);
    check("rst_b_len", b_pl, 32'd0);
    check("rst_b_data", b_data, 32'd0);
    check("rst_b_wr", {31'b0, b_wr}, 32'd0);
    check("rst_b_flt", {31'b0, b_flt}, 32'd0);
    check("rst_c_data", c_data, 32'd0);

    // Instance A: combinational, byte-swapped reads
    load_a(32'h24420000);
    load_a(32'h00000008);
    load_a(32'h12345678);
    check("a_len3", a_pl, 32'd3);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); a_rd = 1'b1; a_addr = vecs[i].addr;
      #1;
      check($sformatf("a_vec%0d_data", i), a_data, vecs[i].data);
      check($sformatf("a_vec%0d_wr", i), {31'b0, a_wr}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("a_vec%0d_flt", i), {31'b0, a_flt}, {31'b0, vecs[i].flt});
    end
    // Same-cycle load and fetch of index 3: old NOP first, new word after the edge
    @(negedge clk); a_addr = 32'hBFC0000C; a_lv = 1'b1; a_ld = 32'hAABBCCDD;
    #1;
    check("a_samecyc_old", a_data, 32'h00000000);
    @(posedge clk); #1;
    a_lv = 1'b0;
    check("a_samecyc_new", a_data, 32'hDDCCBBAA);
    check("a_len4", a_pl, 32'd4);
    @(negedge clk); a_rd = 1'b0;

    // Instance B: wait states, hold, restart, fill
    load_b(32'h11111111);
    load_b(32'h22222222);
    load_b(32'h33333333);
    fetch_b(32'hBFC00000, 32'h11111111, "b_f0");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("b_hold%0d_data", i), b_data, 32'h11111111);
      check($sformatf("b_hold%0d_wr", i), {31'b0, b_wr}, 32'd0);
    end
    @(negedge clk); b_addr = 32'hBFC00004;
    #1;
    check("b_chg_wr", {31'b0, b_wr}, 32'd1);
    @(posedge clk);
    @(negedge clk); b_addr = 32'hBFC00008;
    #1;
    check("b_restart_old", b_data, 32'h11111111);
    n = 0;
    while (b_wr && n < 20) begin
      @(posedge clk); #1;
      if (b_wr) n++;
    end
    check("b_restart_waits", n, 32'd3);
    check("b_restart_data", b_data, 32'h33333333);

    load_b(32'h44444444);
    check("b_full_len", b_pl, 32'd4);
    check("b_full_ready", {31'b0, b_lr}, 32'd0);
    load_b(32'h55555555);
    check("b_over_len", b_pl, 32'd4);
    fetch_b(32'hBFC0000C, 32'h44444444, "b_idx3");

    // Instance B: fault flag set and cleared
    @(negedge clk); b_rd = 1'b0;
    #1;
    check("b_flt_clean", {31'b0, b_flt}, 32'd0);
    fetch_b(32'hBFC00010, 32'h00000000, "b_oow");
    check("b_flt_oow", {31'b0, b_flt}, 32'd1);
    pulse_start_b();
    check("b_flt_clr", {31'b0, b_flt}, 32'd0);
    fetch_b(32'h00000000, 32'h00000000, "b_zero");
    check("b_flt_zero", {31'b0, b_flt}, 32'd1);
    pulse_start_b();
    fetch_b(32'hBFC00002, 32'h00000000, "b_mis");
    check("b_flt_mis", {31'b0, b_flt}, 32'd1);
    pulse_start_b();
    check("b_flt_clr2", {31'b0, b_flt}, 32'd0);

    // Instance B: load_start beats a same-cycle write
    load_b(32'h66666666);
    check("b_len1", b_pl, 32'd1);
    @(negedge clk); b_ls = 1'b1; b_lv = 1'b1; b_ld = 32'hDEADBEEF;
    @(negedge clk); b_ls = 1'b0; b_lv = 1'b0;
    check("b_ls_len", b_pl, 32'd0);
    check("b_ls_ready", {31'b0, b_lr}, 32'd1);
    fetch_b(32'hBFC00000, 32'h00000000, "b_ls_nop");
    load_b(32'h77777777);
    fetch_b(32'hBFC00000, 32'h77777777, "b_reload");
    @(negedge clk); b_rd = 1'b0;

    // Instance C: async reset during WAIT
    load_c(32'h01020304);
    fetch_c(32'hBFC00000, 32'h04030201, "c_f0");
    @(negedge clk); c_addr = 32'hBFC00004;
    @(posedge clk); #1;
    check("c_midwait_wr", {31'b0, c_wr}, 32'd1);
    c_rst = 1'b0;
    #1;
    check("c_rst_wr", {31'b0, c_wr}, 32'd0);
    check("c_rst_data", c_data, 32'd0);
    check("c_rst_len", c_pl, 32'd0);
    @(negedge clk); c_rst = 1'b1;
    fetch_c(32'hBFC00000, 32'h00000000, "c_after");
    @(negedge clk); c_rd = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_instr_rom.md
# mips_instr_rom

Parametrised, loadable instruction memory for the Harvard MIPS CPU and its test benches. It replaces per-test hard-coded instruction decoders with a word array filled through a streaming load port. It serves fetches from a configurable boot window with optional byte swapping and a configurable number of wait states. It sits between the program source (bench or loader) and the CPU instruction port, beside `mips_cpu_data_memory`.

## Interface
- `BASE_ADDR`, default 32'hBFC00000: byte address of word 0.
- `DEPTH`, default 64: number of 32-bit words; must be a power of two, at least 4.
- `READ_LATENCY`, default 0: wait states per fetch, range 0..7. A value of 0 means a combinational read.
- `BYTE_SWAP`, default 1: 1 means output bytes reversed (little-endian storage to big-endian CPU port).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  pulse; clears the load pointer and program length.
- `load_valid`  in  1  load word present.
- `load_data`  in  32  word to store at the load pointer.
- `load_ready`  out  1  space remains (pointer < DEPTH).
- `prog_len`  out  $clog2(DEPTH)+1  words loaded.
- `instr_read`  in  1  fetch request.
- `instr_address`  in  32  fetch byte address.
- `instr_readdata`  out  32  fetched word.
- `instr_waitrequest`  out  1  fetch not yet complete.
- `addr_fault`  out  1  sticky; a fetch fell outside the window or was misaligned.

## Operation
- Word index = (instr_address − BASE_ADDR) >> 2.
- A fetch is in-window when the index < DEPTH and instr_address[1:0] == 0.
- Write: `load_valid && load_ready` stores load_data at mem[prog_len] and increments prog_len.
- `load_start` has priority over a same-cycle write. That write is dropped and prog_len becomes 0.
- Full: prog_len == DEPTH drives load_ready = 0. Further load_valid is ignored; there is no wrap.
- Read word:
  - mem[index] if in-window and index < prog_len.
  - Otherwise 32'h00000000 (NOP).
  - BYTE_SWAP applies to the stored word only. NOP is swap-invariant.
- Fault: an out-of-window or misaligned fetch with instr_read = 1 sets addr_fault. It clears only on reset or load_start.
- Wait-state FSM (READ_LATENCY > 0), states IDLE, WAIT, DONE:
  - IDLE + instr_read goes to WAIT, counter = READ_LATENCY−1.
  - WAIT decrements the counter. At 0 it latches the word into instr_readdata and goes to DONE.
  - DONE holds the data while the address is unchanged and instr_read = 1.
  - In DONE, a new address goes to WAIT (reload counter). instr_read = 0 goes to IDLE.
  - In WAIT, an address change restarts the counter. The old fetch is abandoned.
- READ_LATENCY = 0: the FSM is absent, instr_readdata is combinational from the address, and instr_waitrequest is tied 0.
- Memory array is not reset. prog_len = 0 guarantees every read returns NOP after reset.

## Timing
- Reset values: load_ready 1, prog_len 0, instr_readdata 0, instr_waitrequest 0, addr_fault 0, FSM IDLE.
- Load latency: a word written in cycle t is readable from t+1. With READ_LATENCY = 0 it is readable in the same cycle after the edge.
- Fetch (L = READ_LATENCY > 0), request first sampled at edge t:
  - instr_waitrequest is high combinationally from the request cycle through t+L−1.
  - Data is valid with waitrequest low at t+L.
  - Back-to-back fetches each cost L cycles.
- instr_waitrequest = instr_read && (state != DONE || address changed since latch).
- Reset asserted mid-WAIT: the FSM goes to IDLE immediately (async), waitrequest drops and readdata clears. After deassertion the first request starts a full L-cycle wait.
- Simultaneous load to index k and fetch of index k: the fetch returns the old contents (NOP if k == prog_len before the write).

## Structure
- Package `mips_mem_pkg`: `word_t` (logic [31:0]), `NOP_WORD`, `BOOT_ADDR` = 32'hBFC00000, and the FSM state enum `rom_state_t`.
- Sub-module `mips_rom_wait_ctr`:
  - Contains the wait-state FSM and counter.
  - Inputs: request, address-changed, latency.
  - Outputs: waitrequest, latch_en.
  - Instantiated only under `READ_LATENCY > 0`.
- The top level holds the array, load pointer, window check, swap and fault flag.

## Test plan
- Swap on, L = 0: load 32'h24420000 then 32'h00000008. Fetch BFC00004 → instr_readdata = 32'h08000000, waitrequest 0.
- Swap off, L = 3: fetch BFC00000 after one load → waitrequest high for 3 cycles, then the word is held stable until the address changes. A new address mid-wait restarts the 3-cycle count.
- Fault cases:
  - DEPTH = 4: fetches of BFC00010, address 0 and BFC00002 each return 0 and set addr_fault.
  - load_start clears addr_fault.
- DEPTH = 4: five load_valid words → prog_len = 4, load_ready 0 after the 4th, and the 5th is discarded. Index 3 holds the 4th word.
- Same-cycle load_start and load_valid → prog_len = 0 and no write. A fetch of BFC00000 returns NOP.
- L = 2: assert reset_n low during WAIT → waitrequest 0 and readdata 0 immediately. After release, prog_len = 0 and the next fetch waits 2 cycles and returns 0.
